// File: rtl/ping_sched_pkg.sv
// Shared definitions for the ping ranging scheduler: state encoding,
// the table code written on timeout, and default parameter values.
package ping_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    BUSY  = 3'd2,
    STORE = 3'd3,
    TOUT  = 3'd4,
    GAP   = 3'd5
  } schedState_t;

  localparam logic [7:0] PING_TOUT_CODE = 8'hFF;

  localparam int DEF_NCH         = 4;
  localparam int DEF_CHW         = 2;
  localparam int DEF_GAP_CYC     = 1000;
  localparam int DEF_TIMEOUT_CYC = 50000;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter shared by the timeout and settling-gap phases.
// Load wins over decrement; the count parks at zero rather than wrapping.
module sched_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count down from the loaded value and hold once zero is reached.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ping_scheduler.sv
// Round-robin scheduler sharing one ping ranging core among NCH sensors.
// Define PING_SCHED_NEAREST_EN to add the nearest-obstacle tracker outputs
// (near_dist / near_chan); the default build has neither.
module ping_scheduler
  import ping_sched_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CHW         = DEF_CHW,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic           core_go,
  output logic           core_rst,
  input  logic           core_convdone,
  input  logic [7:0]     core_result,
  input  logic           core_pulseout,
  input  logic           core_pulseen,
  output logic           core_pulsein,
  output logic [NCH-1:0] sens_pulseout,
  output logic [NCH-1:0] sens_pulseen,
  input  logic [NCH-1:0] sens_pulsein,
  input  logic [CHW-1:0] rd_sel,
  output logic [7:0]     rd_data,
  output logic [NCH-1:0] valid,
  output logic [NCH-1:0] err,
  output logic [CHW-1:0] cur_chan,
  output logic           sample_strobe
`ifdef PING_SCHED_NEAREST_EN
  ,
  output logic [7:0]     near_dist,
  output logic [CHW-1:0] near_chan
`endif
);

  localparam int TW = $clog2(maxInt(TIMEOUT_CYC, GAP_CYC)) + 1;

  schedState_t    r_state;
  logic [CHW-1:0] r_curChan;
  logic [7:0]     r_table [NCH];
  logic [NCH-1:0] r_valid;
  logic [NCH-1:0] r_err;
  logic           r_coreGo;
  logic           r_coreRst;
  logic           r_sampleStrobe;

  logic           w_timerLoad;
  logic           w_timerDec;
  logic [TW-1:0]  w_timerVal;
  logic           w_timerZero;
  logic [NCH-1:0] w_sensOut;
  logic [NCH-1:0] w_sensEn;

  // The timer is reloaded when a phase starts: timeout window from GO,
  // settling gap from either result-writing state.
  always_comb begin
    w_timerLoad = (r_state == GO) || (r_state == STORE) || (r_state == TOUT);
    w_timerDec  = (r_state == BUSY) || (r_state == GAP);
    w_timerVal  = (r_state == GO) ? TW'(TIMEOUT_CYC - 1) : TW'(GAP_CYC - 1);
  end

  sched_timer #(
    .W(TW)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_timerLoad),
    .i_loadVal(w_timerVal),
    .i_dec    (w_timerDec),
    .o_zero   (w_timerZero)
  );

  // Measurement sequencer. core_go follows GO by one cycle; core_rst is
  // raised on the edge into TOUT so the core is reset during TOUT itself;
  // sample_strobe appears together with the new table contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_curChan      <= '0;
      r_valid        <= '0;
      r_err          <= '0;
      r_coreGo       <= 1'b0;
      r_coreRst      <= 1'b0;
      r_sampleStrobe <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      r_coreGo       <= 1'b0;
      r_coreRst      <= 1'b0;
      r_sampleStrobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= GO;
          end
        end
        GO: begin
          r_coreGo <= 1'b1;
          r_state  <= BUSY;
        end
        BUSY: begin
          if (core_convdone) begin
            r_state <= STORE;
          end else if (w_timerZero) begin
            r_coreRst <= 1'b1;
            r_state   <= TOUT;
          end
        end
        STORE: begin
          r_table[r_curChan] <= core_result;
          r_valid[r_curChan] <= 1'b1;
          r_err[r_curChan]   <= 1'b0;
          r_sampleStrobe     <= 1'b1;
          r_state            <= GAP;
        end
        TOUT: begin
          r_table[r_curChan] <= PING_TOUT_CODE;
          r_valid[r_curChan] <= 1'b0;
          r_err[r_curChan]   <= 1'b1;
          r_sampleStrobe     <= 1'b1;
          r_state            <= GAP;
        end
        GAP: begin
          if (w_timerZero) begin
            r_curChan <= (r_curChan == CHW'(NCH - 1)) ? '0 : r_curChan + CHW'(1);
            r_state   <= enable ? GO : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Only the selected sensor sees the core's trigger and drive-enable.
  always_comb begin
    w_sensOut            = '0;
    w_sensEn             = '0;
    w_sensOut[r_curChan] = core_pulseout;
    w_sensEn[r_curChan]  = core_pulseen;
  end

  assign core_pulsein  = sens_pulsein[r_curChan];
  assign sens_pulseout = w_sensOut;
  assign sens_pulseen  = w_sensEn;
  assign rd_data       = (int'(rd_sel) < NCH) ? r_table[rd_sel] : 8'h00;
  assign valid         = r_valid;
  assign err           = r_err;
  assign cur_chan      = r_curChan;
  assign core_go       = r_coreGo;
  assign core_rst      = r_coreRst;
  assign sample_strobe = r_sampleStrobe;

`ifdef PING_SCHED_NEAREST_EN
  logic [7:0]     w_minDist;
  logic [CHW-1:0] w_minChan;
  logic [7:0]     r_nearDist;
  logic [CHW-1:0] r_nearChan;

  // Smallest valid entry; strict compare keeps the lowest channel on ties.
  always_comb begin
    w_minDist = PING_TOUT_CODE;
    w_minChan = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_valid[i] && (r_table[i] < w_minDist)) begin
        w_minDist = r_table[i];
        w_minChan = CHW'(i);
      end
    end
  end

  // Capture the minimum once the freshly written entry is in the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nearDist <= PING_TOUT_CODE;
      r_nearChan <= '0;
    end else if (r_sampleStrobe) begin
      r_nearDist <= w_minDist;
      r_nearChan <= w_minChan;
    end
  end

  assign near_dist = r_nearDist;
  assign near_chan = r_nearChan;
`endif

endmodule

// File: doc/ping_scheduler.md
Name: ping_scheduler

Overview:
- Round-robin sequencer that shares one ping ranging core among NCH ultrasonic sensors.
- Per measurement it:
  - routes the selected sensor's pulse lines to the core;
  - issues a one-cycle go and waits for convdone;
  - stores the 8-bit result in a per-channel table;
  - inserts a settling gap, then advances to the next channel.
- A timeout recovers from absent or dead sensors by resetting the core.

Parameters:
- NCH, 4: number of sensor channels (2..16).
- CHW, 2: channel index width, equal to clog2(NCH).
- GAP_CYC, 1000: idle cycles between measurements (>=2).
- TIMEOUT_CYC, 50000: maximum cycles from go to convdone before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run the scan; when low, stop after the current measurement
- core_go  out  1  go pulse to the ranging core
- core_rst  out  1  one-cycle reset to the core on timeout
- core_convdone  in  1  conversion-done from the core
- core_result  in  8  distance result from the core
- core_pulseout  in  1  trigger pulse from the core
- core_pulseen  in  1  drive-enable from the core
- core_pulsein  out  1  echo from the selected sensor to the core
- sens_pulseout  out  NCH  per-sensor trigger
- sens_pulseen  out  NCH  per-sensor drive-enable
- sens_pulsein  in  NCH  per-sensor echo
- rd_sel  in  CHW  table read index
- rd_data  out  8  table entry at rd_sel (combinational)
- valid  out  NCH  entry holds a good sample
- err  out  NCH  last attempt on the channel timed out
- cur_chan  out  CHW  channel being measured
- sample_strobe  out  1  one-cycle pulse when any table entry is written

Behaviour:
- Reset (synchronous, active-high), applied even mid-measurement:
  - state IDLE, cur_chan=0, table all 0, valid=0, err=0;
  - core_go=0, core_rst=0, sample_strobe=0, timer=0.
- IDLE: enable=1 -> GO.
- GO:
  - core_go=1 for exactly one cycle;
  - timer loads TIMEOUT_CYC-1;
  - -> BUSY.
- BUSY: timer decrements each cycle.
  - core_convdone=1 -> STORE. This takes priority if the timer hits 0 in the same cycle.
  - timer==0 with no convdone -> TOUT.
- STORE (one cycle):
  - table[cur_chan] <= core_result;
  - valid[cur_chan] <= 1, err[cur_chan] <= 0;
  - sample_strobe=1;
  - timer loads GAP_CYC-1; -> GAP.
- TOUT (one cycle):
  - core_rst=1;
  - table[cur_chan] <= 8'hFF;
  - valid[cur_chan] <= 0, err[cur_chan] <= 1;
  - sample_strobe=1;
  - timer loads GAP_CYC-1; -> GAP.
- GAP:
  - timer decrements;
  - at 0: cur_chan <= (cur_chan==NCH-1) ? 0 : cur_chan+1;
  - then -> GO if enable, else IDLE.
- enable drop during GO/BUSY/STORE/GAP: the measurement completes normally; the scan stops after GAP.
- Routing:
  - core_pulsein = sens_pulsein[cur_chan];
  - sens_pulseout and sens_pulseen carry the core values only on bit cur_chan, all other bits 0;
  - cur_chan changes only on the GAP exit edge, so routing is stable for an entire measurement.
- Latency: go to store = core conversion time + 1 cycle. Minimum period per channel = conversion + GAP_CYC + 2 cycles.
- Read/write collision: rd_data reflects the old value in the STORE/TOUT cycle and the new value in the next cycle.

Optional Feature:
- Macro: PING_SCHED_NEAREST_EN.
- Defined:
  - adds outputs near_dist[7:0] and near_chan[CHW-1:0];
  - after each STORE, they track the minimum valid table entry;
  - ties go to the lowest channel;
  - reset values 8'hFF and 0;
  - TOUT entries are excluded.
- Undefined: no such ports and no comparison logic.

Decomposition:
- Package ping_sched_pkg holds:
  - state encoding constants IDLE/GO/BUSY/STORE/TOUT/GAP;
  - PING_TOUT_CODE=8'hFF;
  - default parameter values.
- Sub-module sched_timer: loadable down-counter with load, dec and zero flag, shared by the gap and timeout functions.

Test Plan:
- Parameters for the bench: NCH=4, GAP_CYC=4, TIMEOUT_CYC=20.
- Reset then enable=1:
  - core_go pulses one cycle in the cycle after GO is entered, cur_chan=0;
  - convdone with core_result=8'h2A -> next cycle table[0]=2A, valid=0001, sample_strobe=1.
- Full scan returning results 10, 20, 30, 40:
  - cur_chan sequence 0,1,2,3,0;
  - exactly GAP_CYC GAP cycles between STORE and the next GO.
- Channel 2 never produces convdone:
  - 20 cycles after go -> core_rst=1 for one cycle;
  - table[2]=FF, err=0100, valid bit 2=0;
  - scan continues with channel 3.
- Drop enable during BUSY of channel 1: result stored, GAP completes, cur_chan=2, state IDLE, no further core_go.
- Routing: with cur_chan=3, sens_pulsein=4'b1000 -> core_pulsein=1, and core_pulseout=1 -> sens_pulseout=4'b1000; with sens_pulsein=4'b0111 -> core_pulsein=0.
- Reset asserted during BUSY: next cycle state IDLE, table and valid cleared, core_go=0.
